edge_pulse_generator: RTL and testbench

Programmable pulse-train source that emits a requested number of rising edges with programmable high and low phase lengths. It is the transmit-side counterpart of the edge counter. The same `counterByte`/`width` sizing lets a generated train be looped back into a counter and checked count-for-count. It sits in the test/stimulus path, driven by the same gated `internalClock` domain as the counter.

---
 rtl/edge_pulse_generator.sv | 148 ++++++++++++++
 tb/tb_edge_pulse_generator.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/edge_pulse_generator.sv
// Programmable pulse-train source: N rising edges, H cycles high, L cycles low.
// Optional continuous retrigger with the EDGE_GEN_REPEAT_EN macro (adds input repeatTrain).
//
// state | meaning
// IDLE  | waiting for start
// HIGH  | pulseOut high, high-phase timer running
// LOW   | pulseOut low, low-phase timer running
// DONE  | one-cycle completion strobe; start is accepted here as well

module edge_pulse_generator #(
  parameter int counterByte = 2,
  parameter int width       = counterByte * 8,
  parameter int periodWidth = 8
) (
  input  logic                   internalClock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
`ifdef EDGE_GEN_REPEAT_EN
  input  logic                   repeatTrain,
`endif
  input  logic [width-1:0]       pulseCount,
  input  logic [periodWidth-1:0] highCycles,
  input  logic [periodWidth-1:0] lowCycles,
  output logic                   pulseOut,
  output logic                   busy,
  output logic                   done,
  output logic [width-1:0]       edgesSent
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  localparam logic [width-1:0]       EONE = width'(1);
  localparam logic [periodWidth-1:0] PONE = periodWidth'(1);

  state_t                 state, stateNext;
  logic [width-1:0]       countLatch, countNext;
  logic [width-1:0]       edgesNext;
  logic [periodWidth-1:0] highReload, highReloadNext;
  logic [periodWidth-1:0] lowReload, lowReloadNext;
  logic [periodWidth-1:0] phaseCnt, phaseNext;
  logic                   pulseNext, busyNext, doneNext;
  logic                   restart;

  // Phase timers count down to zero, so a length of L loads L-1; zero length behaves as one.
  function automatic logic [periodWidth-1:0] reloadOf(input logic [periodWidth-1:0] len);
    return (len == '0) ? '0 : len - PONE;
  endfunction

  always_comb begin
    stateNext      = state;
    countNext      = countLatch;
    highReloadNext = highReload;
    lowReloadNext  = lowReload;
    phaseNext      = phaseCnt;
    edgesNext      = edgesSent;
    restart        = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          countNext      = pulseCount;
          highReloadNext = reloadOf(highCycles);
          lowReloadNext  = reloadOf(lowCycles);
          if (pulseCount == '0) begin
            stateNext = DONE;
            edgesNext = '0;
          end else begin
            stateNext = HIGH;
            edgesNext = EONE;
            phaseNext = reloadOf(highCycles);
          end
        end else if (state == DONE) begin
          stateNext = IDLE;
        end
      end

      HIGH: begin
        if (abort) begin
          stateNext = IDLE;
        end else if (phaseCnt == '0) begin
          stateNext = LOW;
          phaseNext = lowReload;
        end else begin
          phaseNext = phaseCnt - PONE;
        end
      end

      LOW: begin
        if (abort) begin
          stateNext = IDLE;
        end else if (phaseCnt == '0) begin
          if (edgesSent == countLatch) begin
`ifdef EDGE_GEN_REPEAT_EN
            if (repeatTrain) begin
              restart   = 1'b1;
              stateNext = HIGH;
              edgesNext = EONE;
              phaseNext = highReload;
            end else begin
              stateNext = DONE;
            end
`else
            stateNext = DONE;
`endif
          end else begin
            stateNext = HIGH;
            edgesNext = edgesSent + EONE;
            phaseNext = highReload;
          end
        end else begin
          phaseNext = phaseCnt - PONE;
        end
      end

      default: stateNext = IDLE;
    endcase

    pulseNext = (stateNext == HIGH);
    busyNext  = (stateNext == HIGH) || (stateNext == LOW);
    doneNext  = (stateNext == DONE) || restart;
  end

  always_ff @(posedge internalClock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      countLatch <= '0;
      highReload <= '0;
      lowReload  <= '0;
      phaseCnt   <= '0;
      edgesSent  <= '0;
      pulseOut   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= stateNext;
      countLatch <= countNext;
      highReload <= highReloadNext;
      lowReload  <= lowReloadNext;
      phaseCnt   <= phaseNext;
      edgesSent  <= edgesNext;
      pulseOut   <= pulseNext;
      busy       <= busyNext;
      done       <= doneNext;
    end
  end

endmodule

// File: tb/tb_edge_pulse_generator.sv
// Directed bench for edge_pulse_generator (default build): expected per-cycle outputs
// are derived from the train timing formulas, queued at stimulus time and popped per edge.
module tb_edge_pulse_generator;

  typedef struct packed {
    logic        p;
    logic        b;
    logic        d;
    logic [15:0] e;
  } obs_t;

  logic        internalClock = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] pulseCount;
  logic [7:0]  highCycles;
  logic [7:0]  lowCycles;
  logic        pulseOut;
  logic        busy;
  logic        done;
  logic [15:0] edgesSent;

  obs_t expq[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   lbCount    = 0;

  edge_pulse_generator dut (
    .internalClock(internalClock),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .pulseCount   (pulseCount),
    .highCycles   (highCycles),
    .lowCycles    (lowCycles),
    .pulseOut     (pulseOut),
    .busy         (busy),
    .done         (done),
    .edgesSent    (edgesSent)
  );

  always #5 internalClock = ~internalClock;

  // Loopback edge counter on the generated train.
  always @(posedge pulseOut) lbCount++;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check_pop(input string tag, input int t);
    obs_t got, exp;
    got = {pulseOut, busy, done, edgesSent};
    compared++;
    if (expq.size() == 0) begin
      mismatched++;
      $display("FAIL %s t=%0d observed=%h expected=<empty scoreboard>", tag, t, got);
    end else begin
      exp = expq.pop_front();
      assert (got === exp) else begin
        mismatched++;
        $error("FAIL %s t=%0d observed p=%b b=%b d=%b e=%0d expected p=%b b=%b d=%b e=%0d",
               tag, t, got.p, got.b, got.d, got.e, exp.p, exp.b, exp.d, exp.e);
      end
    end
  endtask

  task automatic idle_check(input string tag, input int edges, input int n);
    for (int t = 0; t < n; t++) begin
      expq.push_back({1'b0, 1'b0, 1'b0, 16'(edges)});
      @(posedge internalClock); #1;
      check_pop(tag, t);
    end
  endtask

  // Launch a train sampled at the next edge (k); records t are observed just after edge k+t.
  task automatic run_train(input string tag, input int n, input int h, input int l,
                           input int againAt, input int abortAt, input bit abortWithStart);
    int he, le, per, total, last, ab;
    obs_t r;
    he    = (h == 0) ? 1 : h;
    le    = (l == 0) ? 1 : l;
    per   = he + le;
    total = n * per;
    last  = (abortAt >= 0) ? abortAt + 2 : total;
    for (int t = 0; t <= last; t++) begin
      if (abortAt >= 0 && t >= abortAt) begin
        ab = (abortAt - 1) / per + 1;
        if (ab > n) ab = n;
        r = {1'b0, 1'b0, 1'b0, 16'(ab)};
      end else if (t < total) begin
        r = {((t % per) < he), 1'b1, 1'b0, 16'(t / per + 1)};
      end else begin
        r = {1'b0, 1'b0, 1'b1, 16'(n)};
      end
      expq.push_back(r);
    end
    start      = 1'b1;
    abort      = abortWithStart;
    pulseCount = 16'(n);
    highCycles = 8'(h);
    lowCycles  = 8'(l);
    for (int t = 0; t <= last; t++) begin
      @(posedge internalClock); #1;
      check_pop(tag, t);
      if (t == 0) begin
        start = 1'b0;
        abort = 1'b0;
      end
      if (t == againAt - 1) begin
        start      = 1'b1;
        pulseCount = 16'd7;
        highCycles = 8'd5;
        lowCycles  = 8'd3;
      end
      if (t == againAt) start = 1'b0;
      if (t == abortAt - 1) abort = 1'b1;
      if (t == abortAt) abort = 1'b0;
    end
  endtask

  initial begin
    int base;
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    pulseCount = '0;
    highCycles = '0;
    lowCycles  = '0;
    #3;
    expq.push_back('0);
    check_pop("reset_state", 0);
    @(negedge internalClock);
    reset = 1'b0;
    idle_check("idle_after_reset", 0, 2);

    run_train("basic_n3_h2_l1", 3, 2, 1, -1, -1, 1'b0);
    idle_check("idle_after_basic", 3, 2);

    run_train("n_zero", 0, 4, 4, -1, -1, 1'b0);
    idle_check("idle_after_n0", 0, 1);

    run_train("h0_l0_n4", 4, 0, 0, -1, -1, 1'b0);
    run_train("b2b_start_while_busy", 2, 1, 2, 2, -1, 1'b0);
    idle_check("idle_after_b2b", 2, 1);

    run_train("abort_after_2", 5, 2, 2, -1, 8, 1'b0);
    idle_check("idle_after_abort", 2, 2);

    run_train("abort_with_start", 1, 1, 1, -1, -1, 1'b1);
    idle_check("idle_after_abort_start", 1, 1);

    run_train("max_phase", 1, 255, 255, -1, -1, 1'b0);
    idle_check("idle_after_max_phase", 1, 1);

    base = lbCount;
    run_train("loopback_600", 600, 1, 1, -1, -1, 1'b0);
    compared++;
    assert (lbCount - base === 600) else begin
      mismatched++;
      $error("FAIL loopback_count observed=%0d expected=%0d", lbCount - base, 600);
    end

    // Asynchronous reset in the middle of a high phase.
    @(negedge internalClock);
    start      = 1'b1;
    pulseCount = 16'd5;
    highCycles = 8'd4;
    lowCycles  = 8'd1;
    @(posedge internalClock); #1;
    start = 1'b0;
    @(posedge internalClock); #2;
    reset = 1'b1;
    #1;
    expq.push_back('0);
    check_pop("reset_mid_high", 0);
    @(negedge internalClock);
    reset = 1'b0;
    idle_check("idle_after_mid_reset", 0, 2);
    run_train("recover_after_reset", 1, 1, 1, -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
